rr_arbiter_8: RTL and testbench
===============================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: HOLD_MAX, default 15, range 1..15; maximum consecutive cycles one requester may hold the grant.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req  input  8  request vector; bit i high means requester i wants the shared resource.
REQ-005 Port: gnt  output  8  registered one-hot grant; all-zero when no owner.
REQ-006 Port: gnt_idx  output  3  registered binary index of the current owner; 8-to-3 encoding of gnt.
REQ-007 Port: gnt_valid  output  1  registered; high exactly when gnt is non-zero.
REQ-008 Port: preempt  output  1  registered one-cycle pulse marking a forced release on hold timeout.

Function
REQ-009 States: IDLE (no owner) and BUSY (one owner); internal 3-bit round-robin pointer ptr and 4-bit hold counter hold_cnt.
REQ-010 Selection: first set bit of req, searching upward from ptr and wrapping 7->0; bit ptr has highest priority.
REQ-011 IDLE with req != 0 at edge N: gnt, gnt_idx, gnt_valid reflect the winner from edge N; state -> BUSY; hold_cnt = 1.
REQ-012 IDLE with req == 0: outputs stay zero; ptr unchanged.
REQ-013 BUSY with req[owner] = 1 and hold_cnt < HOLD_MAX: grant held; hold_cnt increments.
REQ-014 BUSY with req[owner] = 0 (voluntary release): ptr = owner+1 mod 8; arbitrate on the same edge with the new ptr.
REQ-015 BUSY with req[owner] = 1 and hold_cnt == HOLD_MAX (timeout): release owner; ptr = owner+1 mod 8; arbitrate on the same edge; preempt = 1 for one cycle.
REQ-016 On release, if the search finds a winner, it is granted on the release edge with no idle bubble; hold_cnt = 1; state stays BUSY.
REQ-017 On release with no winner: gnt = 0, gnt_valid = 0, gnt_idx = 0; state -> IDLE.
REQ-018 Lone requester still asserting at timeout wraps back to itself; it is regranted with hold_cnt = 1, and preempt still pulses.
REQ-019 Requests from non-owners never disturb the current grant before release.
REQ-020 gnt always has at most one bit set; gnt_idx always equals the encoding of gnt when gnt_valid = 1.
REQ-021 ptr changes only on release or timeout, never on the initial IDLE grant.

Reset
REQ-022 rst_n low immediately, without a clock, sets: gnt = 0, gnt_idx = 0, gnt_valid = 0, preempt = 0, ptr = 0, hold_cnt = 0, state = IDLE.
REQ-023 Reset asserted mid-grant drops the grant at once; the first edge after deassertion arbitrates from ptr = 0.
REQ-024 No grant is issued while rst_n is low, regardless of req.

Verification (bench uses HOLD_MAX = 4)
REQ-025 Single request: req = 8'b0000_1000 from reset -> after 1 edge gnt = 8'b0000_1000, gnt_idx = 3, gnt_valid = 1; req -> 0 -> gnt = 0 next edge.
REQ-026 Round-robin fairness: req = 8'b1000_0001 held, each owner drops req for one cycle after grant -> owners alternate 0, 7, 0, 7 with no idle cycle between grants.
REQ-027 Wrap search: owner 6 releases with req = 8'b0000_0011 -> next gnt_idx = 0, then 1.
REQ-028 Timeout: req = 8'b0000_0110 held constant -> requester 1 granted 4 cycles, preempt pulses, requester 2 granted 4 cycles, preempt pulses, back to 1.
REQ-029 Lone hog: req = 8'b0001_0000 held -> gnt_idx stays 4; preempt pulses every 4 cycles; gnt_valid never drops.
REQ-030 Async reset: rst_n pulsed low between edges while gnt_idx = 5 -> all outputs 0 before the next edge; with req = 8'b1111_1111 after release, first grant is gnt_idx = 0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: 8-way round-robin arbiter with registered one-hot grant and hold-timeout preemption
module rr_arbiter_8 #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state, state_n;
    logic [2:0] ptr, ptr_n, search, idx, win, gnt_idx_n;
    logic [3:0] hold_cnt, hold_n;
    logic [7:0] gnt_n;
    logic       valid_n, preempt_n, found, timeout, rel;
    // Release detection and rotating search: a releasing owner hands priority to owner+1 on the same edge
    always_comb begin
        timeout = state == BUSY && req[gnt_idx] && hold_cnt == 4'(HOLD_MAX);
        rel = state == BUSY && (!req[gnt_idx] || timeout);
        search = rel ? gnt_idx + 3'd1 : ptr;
        found = 1'b0;
        win = 3'd0;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = search + 3'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    // Next state: grant from IDLE or on release, otherwise keep the owner and count hold cycles
    always_comb begin
        state_n = state;
        ptr_n = ptr;
        hold_n = hold_cnt;
        gnt_n = gnt;
        gnt_idx_n = gnt_idx;
        valid_n = gnt_valid;
        preempt_n = timeout;
        if (state == IDLE || rel) begin
            ptr_n = search;
            state_n = found ? BUSY : IDLE;
            hold_n = found ? 4'd1 : 4'd0;
            gnt_n = found ? 8'd1 << win : 8'd0;
            gnt_idx_n = found ? win : 3'd0;
            valid_n = found;
        end else begin
            hold_n = hold_cnt + 4'd1;
        end
    end
    // State and output registers; reset clears the grant immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= 3'd0;
            hold_cnt <= 4'd0;
            gnt <= 8'd0;
            gnt_idx <= 3'd0;
            gnt_valid <= 1'b0;
            preempt <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            hold_cnt <= hold_n;
            gnt <= gnt_n;
            gnt_idx <= gnt_idx_n;
            gnt_valid <= valid_n;
            preempt <= preempt_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: directed-vector bench for rr_arbiter_8 with HOLD_MAX = 4
module tb_rr_arbiter_8;
    logic       clk, rst_n;
    logic [7:0] req, gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid, preempt;
    int         vectors = 0, miscompares = 0;

    rr_arbiter_8 #(.HOLD_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .preempt(preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // observed bundle: {gnt, gnt_idx, gnt_valid, preempt}
    function automatic logic [12:0] outs();
        return {gnt, gnt_idx, gnt_valid, preempt};
    endfunction

    function automatic logic [12:0] exp_o(input logic [2:0] i, input logic v, input logic p);
        logic [7:0] g;
        g = v ? 8'd1 << i : 8'd0;
        return {g, v ? i : 3'd0, v, p};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b idx=%0d v=%b pre=%b, expected gnt=%b idx=%0d v=%b pre=%b",
                     tag, got[12:5], got[4:2], got[1], got[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int ex28_idx[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        bit ex28_pre[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        rst_n = 1'b1;
        req = 8'h00;
        #2 rst_n = 1'b0;
        #1 check("reset_async", outs(), exp_o(0, 0, 0));
        req = 8'hFF;
        tick();
        tick();
        check("no_grant_in_reset", outs(), exp_o(0, 0, 0));

        // single request
        do_reset();
        req = 8'h08;
        tick();
        check("single_grant", outs(), exp_o(3, 1, 0));
        req = 8'h00;
        tick();
        check("single_release", outs(), exp_o(0, 0, 0));

        // fairness between 0 and 7, no idle bubble
        do_reset();
        req = 8'h81;
        tick();
        check("rr_first_0", outs(), exp_o(0, 1, 0));
        req = 8'h80;
        tick();
        check("rr_then_7", outs(), exp_o(7, 1, 0));
        req = 8'h01;
        tick();
        check("rr_then_0", outs(), exp_o(0, 1, 0));
        req = 8'h80;
        tick();
        check("rr_then_7b", outs(), exp_o(7, 1, 0));

        // wrap search from owner 6
        do_reset();
        req = 8'h40;
        tick();
        check("wrap_own6", outs(), exp_o(6, 1, 0));
        req = 8'h03;
        tick();
        check("wrap_to_0", outs(), exp_o(0, 1, 0));
        req = 8'h02;
        tick();
        check("wrap_to_1", outs(), exp_o(1, 1, 0));

        // timeout rotation between 1 and 2
        do_reset();
        req = 8'h06;
        for (int t = 0; t < 9; t++) begin
            tick();
            check($sformatf("timeout_t%0d", t + 1), outs(), exp_o(3'(ex28_idx[t]), 1, ex28_pre[t]));
        end

        // lone hog regranted to itself
        do_reset();
        req = 8'h10;
        for (int t = 1; t <= 12; t++) begin
            tick();
            check($sformatf("hog_t%0d", t), outs(), exp_o(4, 1, t > 1 && t % 4 == 1));
        end

        // async reset mid-grant
        do_reset();
        req = 8'h20;
        tick();
        check("pre_rst_own5", outs(), exp_o(5, 1, 0));
        rst_n = 1'b0;
        #2 check("mid_rst_clear", outs(), exp_o(0, 0, 0));
        req = 8'hFF;
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_ptr0", outs(), exp_o(0, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
